// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - single-port data SRAM responder with post-reset clear sweep
module data_sram_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        sram_ready,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [31:0]       mem [0:DEPTH-1];

    logic [31:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;

    logic [3:0]        wr_be;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [31:0]       rd_merge;

    // Wrap-around offset; anything at or beyond 4*DEPTH (including below BASE) is out of range
    assign off      = data_sram_addr - BASE_ADDR;
    assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
    assign idx      = off[ADDR_W+1:2];

    // Shared write port: the clear sweep and pipeline stores both go through it
    always_comb begin
        wr_be   = 4'h0;
        wr_idx  = idx;
        wr_data = data_sram_wdata;
        if (!rst) begin
            if (state == INIT) begin
                wr_be   = 4'hF;
                wr_idx  = clr_cnt;
                wr_data = 32'h0;
            end else if (in_range) begin
                wr_be = data_sram_we;
            end
        end
    end

    // Write-first read value: stored word with this cycle's enabled bytes replaced
    always_comb begin
        rd_merge = mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (data_sram_we[b]) begin
                rd_merge[8*b +: 8] = data_sram_wdata[8*b +: 8];
            end
        end
    end

    // Byte-enabled storage write
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Sweep/run control with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            clr_cnt         <= '0;
            data_sram_rdata <= 32'h0;
            sram_ready      <= 1'b0;
            addr_err        <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    data_sram_rdata <= 32'h0;
                    addr_err        <= 1'b0;
                    clr_cnt         <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state      <= RUN;
                        sram_ready <= 1'b1;
                    end
                end
                RUN: begin
                    sram_ready      <= 1'b1;
                    addr_err        <= !in_range;
                    data_sram_rdata <= in_range ? rd_merge : 32'h0;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
